data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-ported DataMemory between two requesters.
- Port 0 is the CPU MEM stage. Port 1 is the program loader / debug access port.
- Performs round-robin arbitration and sequences MemRead/MemWrite for a fixed memory latency.
- Captures ReadData, returns a one-cycle Ack per transaction, and rejects out-of-range addresses without touching memory.

Parameters:
- MEM_LATENCY, 2: cycles MemRead/MemWrite are held per access (legal 1..15).
- MEM_WORDS, 256: number of valid word addresses; Addr >= MEM_WORDS is an error.
- DATA_WIDTH, 32: data and address width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req0 / Req1  in  1  request from port 0 / port 1; held high until Ack.
- We0 / We1  in  1  1 = write, 0 = read; stable while Req is high.
- Addr0 / Addr1  in  32  word address; stable while Req is high.
- WData0 / WData1  in  32  write data; stable while Req is high.
- Ack0 / Ack1  out  1  one-cycle completion pulse.
- Err0 / Err1  out  1  valid with Ack; 1 = address out of range.
- RData  out  32  read result; valid in the Ack cycle.
- Busy  out  1  high in ACCESS and RESP.
- Address  out  32  to DataMemory.
- WriteData  out  32  to DataMemory.
- MemRead  out  1  to DataMemory.
- MemWrite  out  1  to DataMemory.
- ReadData  in  32  from DataMemory.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; all outputs 0; wait counter 0; priority pointer = port 0.
  - Reset mid-transaction aborts immediately: MemRead/MemWrite drop asynchronously, no Ack is issued, the transaction is lost.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: sample Req0/Req1.
  - None asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port named by the priority pointer.
  - On grant, latch Addr/We/WData of the winner into internal registers and toggle the pointer to the other port.
  - Granted address in range: go to ACCESS, counter = MEM_LATENCY-1.
  - Granted address out of range: go straight to RESP with Err=1. No memory strobe.
- ACCESS:
  - Address/WriteData driven from the latched registers.
  - MemWrite = latched We; MemRead = !latched We.
  - Counter decrements each cycle.
  - At counter 0 (after exactly MEM_LATENCY cycles): if read, register ReadData into RData; go to RESP.
- RESP:
  - Ack of the granted port = 1 for exactly one cycle; Err as determined.
  - MemRead = MemWrite = 0. Next state IDLE.
- Latency: request sampled in IDLE cycle t; strobes active cycles t+1..t+MEM_LATENCY; Ack in cycle t+MEM_LATENCY+1.
  - Error case: Ack in cycle t+1.
- Back-to-back: a requester may keep Req high after Ack to issue a new request; it is re-sampled in the following IDLE cycle.
  - With both ports requesting continuously, grants alternate 0,1,0,1.
- RData:
  - Holds its value until the next completed read.
  - A write or error completion leaves RData unchanged, except that error completion forces RData=0.
- Address, WriteData, MemRead and MemWrite are 0 whenever state != ACCESS, so no stray memory writes occur.
- The inactive port's Ack/Err stay 0.
- Req dropped mid-transaction by the owner: the transaction still completes and Ack is still pulsed.

Test Plan:
- Reset, Req0=1, We0=1, Addr0=2, WData0=1, MEM_LATENCY=2 -> MemWrite=1 with Address=2, WriteData=1 for exactly 2 cycles; Ack0 pulses one cycle, 3 cycles after sampling; Err0=0.
- Then Req0=1, We0=0, Addr0=2 -> MemRead=1 for 2 cycles; Ack0 with RData=1. Read of Addr0=3 (never written) -> RData equals memory content of word 3.
- Req0 and Req1 both held high from reset, reads of 5 and 6 -> grant order port0, port1, port0, port1; Acks never overlap; each RData matches its own address.
- Req1=1, Addr1=300 (MEM_WORDS=256) -> MemRead/MemWrite never asserted; Ack1=1, Err1=1, RData=0 one cycle after sampling.
- Reset_n pulled low during ACCESS of a write -> MemWrite drops in the same cycle, no Ack; after release, Req1 wins first only if Req0=0 (pointer back to port 0).
- MEM_LATENCY=1 regression of the first two scenarios -> strobes for 1 cycle, Ack 2 cycles after sampling.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-ported DataMemory between the CPU MEM
// stage (port 0) and the loader/debug port (port 1), with fixed-latency strobes.
module data_mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int MEM_WORDS   = 256,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Req0,
    input  logic                  Req1,
    input  logic                  We0,
    input  logic                  We1,
    input  logic [DATA_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WData0,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic                  Ack0,
    output logic                  Ack1,
    output logic                  Err0,
    output logic                  Err1,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Busy,
    output logic [DATA_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  MemRead,
    output logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] ReadData
);

    localparam logic [DATA_WIDTH-1:0] LP_WORDS    = DATA_WIDTH'(MEM_WORDS);
    localparam logic [3:0]            LP_CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_ptr;
    logic                  r_owner;
    logic                  r_we;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_req_any;
    logic                  w_sel;
    logic [DATA_WIDTH-1:0] w_sel_addr;
    logic                  w_in_range;

    // With a single requester it wins outright; the pointer only breaks ties.
    assign w_req_any  = Req0 | Req1;
    assign w_sel      = (Req0 & Req1) ? r_ptr : Req1;
    assign w_sel_addr = w_sel ? Addr1 : Addr0;
    assign w_in_range = (w_sel_addr < LP_WORDS);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req_any) w_next = w_in_range ? S_ACCESS : S_RESP;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner <= w_sel;
                        r_ptr   <= ~w_sel;
                        r_we    <= w_sel ? We1 : We0;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel ? WData1 : WData0;
                        r_err   <= ~w_in_range;
                        r_cnt   <= LP_CNT_INIT;
                        if (!w_in_range) r_rdata <= '0;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                    else if (!r_we)    r_rdata <= ReadData;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from state alone, so an async reset drops them at once.
    always_comb begin
        Ack0      = 1'b0;
        Ack1      = 1'b0;
        Err0      = 1'b0;
        Err1      = 1'b0;
        Busy      = 1'b0;
        Address   = '0;
        WriteData = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        case (r_state)
            S_ACCESS: begin
                Busy      = 1'b1;
                Address   = r_addr;
                WriteData = r_wdata;
                MemWrite  = r_we;
                MemRead   = ~r_we;
            end
            S_RESP: begin
                Busy = 1'b1;
                Ack0 = ~r_owner;
                Ack1 = r_owner;
                Err0 = ~r_owner & r_err;
                Err1 = r_owner & r_err;
            end
            default: ;
        endcase
    end

    assign RData = r_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: per-cycle vector tables for latency 2 and 1,
// plus sequences for round-robin, out-of-range and mid-access reset.
module tb_data_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Req0, Req1, We0, We1;
    logic [31:0] Addr0, Addr1, WData0, WData1;

    logic        ack0_a, ack1_a, err0_a, err1_a, busy_a, mr_a, mw_a;
    logic [31:0] rdata_a, adr_a, wd_a, rdm_a;
    logic        ack0_b, ack1_b, err0_b, err1_b, busy_b, mr_b, mw_b;
    logic [31:0] rdata_b, adr_b, wd_b, rdm_b;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    data_mem_arbiter #(.MEM_LATENCY(2), .MEM_WORDS(256), .DATA_WIDTH(32)) dut_a (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(ack0_a), .Ack1(ack1_a), .Err0(err0_a), .Err1(err1_a),
        .RData(rdata_a), .Busy(busy_a), .Address(adr_a), .WriteData(wd_a),
        .MemRead(mr_a), .MemWrite(mw_a), .ReadData(rdm_a)
    );

    data_mem_arbiter #(.MEM_LATENCY(1), .MEM_WORDS(256), .DATA_WIDTH(32)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(ack0_b), .Ack1(ack1_b), .Err0(err0_b), .Err1(err1_b),
        .RData(rdata_b), .Busy(busy_b), .Address(adr_b), .WriteData(wd_b),
        .MemRead(mr_b), .MemWrite(mw_b), .ReadData(rdm_b)
    );

    function automatic logic [31:0] memi(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    // Behavioural DataMemory per DUT; first clock loads the known pattern.
    logic        mem_ready = 1'b0;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    always @(posedge Clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= memi(i);
                mem_b[i] <= memi(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (mw_a) mem_a[adr_a[7:0]] <= wd_a;
            if (mw_b) mem_b[adr_b[7:0]] <= wd_b;
        end
    end

    assign rdm_a = mem_a[adr_a[7:0]];
    assign rdm_b = mem_b[adr_b[7:0]];

    // status = {Ack0, Ack1, Err0, Err1, MemRead, MemWrite, Busy}
    function automatic logic [6:0] st_a();
        return {ack0_a, ack1_a, err0_a, err1_a, mr_a, mw_a, busy_a};
    endfunction
    function automatic logic [6:0] st_b();
        return {ack0_b, ack1_b, err0_b, err1_b, mr_b, mw_b, busy_b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        req0;
        logic        we0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [6:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          chk_rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [6:0] st,
                                input logic [31:0] ad, input logic [31:0] wd,
                                input logic [31:0] rd, input bit cr);
        vec_t v;
        v.req0 = r; v.we0 = w; v.a0 = a; v.d0 = d; v.st = st;
        v.addr = ad; v.wdata = wd; v.rdata = rd; v.chk_rd = cr;
        return v;
    endfunction

    // Entered and left at posedge+2; outputs are checked at posedge+3.
    task automatic run_vec(input vec_t v, input bit use_b, input string tag, input int idx);
        Req0 = v.req0; We0 = v.we0; Addr0 = v.a0; WData0 = v.d0;
        Req1 = 1'b0; We1 = 1'b0; Addr1 = '0; WData1 = '0;
        #1;
        if (use_b) begin
            chk($sformatf("%s%0d_status", tag, idx), 32'(st_b()), 32'(v.st));
            chk($sformatf("%s%0d_address", tag, idx), adr_b, v.addr);
            chk($sformatf("%s%0d_wdata", tag, idx), wd_b, v.wdata);
            if (v.chk_rd) chk($sformatf("%s%0d_rdata", tag, idx), rdata_b, v.rdata);
        end else begin
            chk($sformatf("%s%0d_status", tag, idx), 32'(st_a()), 32'(v.st));
            chk($sformatf("%s%0d_address", tag, idx), adr_a, v.addr);
            chk($sformatf("%s%0d_wdata", tag, idx), wd_a, v.wdata);
            if (v.chk_rd) chk($sformatf("%s%0d_rdata", tag, idx), rdata_a, v.rdata);
        end
        @(posedge Clock); #2;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Req0 = 1'b0; We0 = 1'b0; Addr0 = '0; WData0 = '0;
        Req1 = 1'b0; We1 = 1'b0; Addr1 = '0; WData1 = '0;
        repeat (2) @(posedge Clock);
        #3;
        chk("reset_status_a", 32'(st_a()), 32'h0);
        chk("reset_status_b", 32'(st_b()), 32'h0);
        chk("reset_outs_a", adr_a | wd_a | rdata_a, 32'h0);
        chk("reset_outs_b", adr_b | wd_b | rdata_b, 32'h0);
        @(posedge Clock); #2;
        Reset_n = 1'b1;
    endtask

    vec_t tab_a [13];
    vec_t tab_b [7];
    int   nack;
    bit   found;

    initial begin
        // Latency 2: write 1 to word 2, read it back, then read unwritten word 3.
        tab_a[0]  = mk(1, 1, 2, 1, 7'b0000000, 0, 0, 0, 1);
        tab_a[1]  = mk(1, 1, 2, 1, 7'b0000011, 2, 1, 0, 0);
        tab_a[2]  = mk(1, 1, 2, 1, 7'b0000011, 2, 1, 0, 0);
        tab_a[3]  = mk(0, 0, 0, 0, 7'b1000001, 0, 0, 0, 0);
        tab_a[4]  = mk(1, 0, 2, 0, 7'b0000000, 0, 0, 0, 1);
        tab_a[5]  = mk(1, 0, 2, 0, 7'b0000101, 2, 0, 0, 0);
        tab_a[6]  = mk(1, 0, 2, 0, 7'b0000101, 2, 0, 0, 0);
        tab_a[7]  = mk(0, 0, 0, 0, 7'b1000001, 0, 0, 1, 1);
        tab_a[8]  = mk(1, 0, 3, 0, 7'b0000000, 0, 0, 1, 1);
        tab_a[9]  = mk(1, 0, 3, 0, 7'b0000101, 3, 0, 0, 0);
        tab_a[10] = mk(1, 0, 3, 0, 7'b0000101, 3, 0, 0, 0);
        tab_a[11] = mk(0, 0, 0, 0, 7'b1000001, 0, 0, 32'hA000_0003, 1);
        tab_a[12] = mk(0, 0, 0, 0, 7'b0000000, 0, 0, 32'hA000_0003, 1);
        // Latency 1: same write/read pair, one strobe cycle each.
        tab_b[0]  = mk(1, 1, 2, 1, 7'b0000000, 0, 0, 0, 1);
        tab_b[1]  = mk(1, 1, 2, 1, 7'b0000011, 2, 1, 0, 0);
        tab_b[2]  = mk(0, 0, 0, 0, 7'b1000001, 0, 0, 0, 0);
        tab_b[3]  = mk(1, 0, 2, 0, 7'b0000000, 0, 0, 0, 1);
        tab_b[4]  = mk(1, 0, 2, 0, 7'b0000101, 2, 0, 0, 0);
        tab_b[5]  = mk(0, 0, 0, 0, 7'b1000001, 0, 0, 1, 1);
        tab_b[6]  = mk(0, 0, 0, 0, 7'b0000000, 0, 0, 1, 1);

        do_reset();
        for (int i = 0; i < 13; i++) run_vec(tab_a[i], 1'b0, "l2_v", i);
        do_reset();
        for (int i = 0; i < 7; i++) run_vec(tab_b[i], 1'b1, "l1_v", i);

        // Both ports held from reset: grants must alternate 0,1,0,1.
        do_reset();
        Req0 = 1; We0 = 0; Addr0 = 5; Req1 = 1; We1 = 0; Addr1 = 6;
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            #1;
            if (ack0_a || ack1_a) begin
                chk("rr_overlap", 32'(ack0_a & ack1_a), 32'h0);
                chk($sformatf("rr_port%0d", nack), 32'(ack1_a), 32'(nack % 2));
                chk($sformatf("rr_rdata%0d", nack), rdata_a, ack1_a ? memi(6) : memi(5));
                nack++;
                if (nack == 4) begin Req0 = 0; Req1 = 0; end
            end
            @(posedge Clock); #2;
        end
        chk("rr_ack_count", 32'(nack), 32'd4);

        // Out-of-range address on port 1: no strobes, Err with Ack next cycle.
        Req1 = 1; We1 = 0; Addr1 = 300;
        #1;
        chk("err_idle_status", 32'(st_a()), 32'h0);
        @(posedge Clock); #2;
        Req1 = 0;
        #1;
        chk("err_resp_status", 32'(st_a()), 32'(7'b0101001));
        chk("err_resp_rdata", rdata_a, 32'h0);
        chk("err_resp_address", adr_a, 32'h0);
        @(posedge Clock); #2;
        #1;
        chk("err_after_status", 32'(st_a()), 32'h0);
        @(posedge Clock); #2;

        // Reset during a write access; pointer (now port 1) must return to port 0.
        Req0 = 1; We0 = 1; Addr0 = 7; WData0 = 32'hDEAD;
        @(posedge Clock); #3;
        chk("rst_access_status", 32'(st_a()), 32'(7'b0000011));
        Reset_n = 1'b0;
        #1;
        chk("rst_abort_status", 32'(st_a()), 32'h0);
        Req0 = 0; We0 = 0;
        @(posedge Clock); #2;
        chk("rst_hold_status", 32'(st_a()), 32'h0);
        Reset_n = 1'b1;
        Req0 = 1; We0 = 0; Addr0 = 8; Req1 = 1; We1 = 0; Addr1 = 9;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (ack0_a || ack1_a) begin
                found = 1;
                chk("rst_first_grant_ack0", 32'(ack0_a), 32'h1);
                chk("rst_first_grant_ack1", 32'(ack1_a), 32'h0);
                chk("rst_first_rdata", rdata_a, memi(8));
                Req0 = 0; Req1 = 0;
            end
            @(posedge Clock); #2;
        end
        chk("rst_first_ack_seen", 32'(found), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
